// File: rtl/encoder16x4_seq_pkg.sv
// Shared constants and FSM encoding for the sequential 16-to-4 priority encoder.
package encoder_pkg;

    localparam int unsigned N      = 16;
    localparam int unsigned CODE_W = $clog2(N);

    typedef enum logic {
        IDLE    = 1'b0,
        PRESENT = 1'b1
    } state_e;

endpackage

// File: rtl/encoder16x4_seq_pri_enc16.sv
// Combinational priority encoder: index of the highest set bit, plus an any-set flag.
module pri_enc16
    import encoder_pkg::*;
(
    input  logic [N-1:0]      vec,
    output logic [CODE_W-1:0] idx,
    output logic              any
);

    // Ascending scan so the highest set bit is the last assignment to stick.
    always_comb begin
        idx = '0;
        for (int i = 0; i < N; i++) begin
            if (vec[i]) begin
                idx = CODE_W'(i);
            end
        end
        any = |vec;
    end

endmodule

// File: rtl/encoder16x4_seq.sv
// Sequential 16-to-4 priority encoder: accumulates requests into a pending
// register and serves them highest index first over a valid/ready handshake.
module encoder16x4_seq
    import encoder_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              load,
    input  logic [N-1:0]      req_in,
    input  logic              ready,
    output logic [CODE_W-1:0] code_out,
    output logic              valid,
    output logic              busy
);

    state_e              state_q, state_d;
    logic [N-1:0]        pending_q, pending_d;
    logic [CODE_W-1:0]   code_q, code_d;
    logic                valid_q, valid_d;

    logic [N-1:0]        load_vec;
    logic [N-1:0]        clr_mask;
    logic [N-1:0]        next_pending;
    logic [N-1:0]        enc_vec;
    logic [CODE_W-1:0]   enc_idx;
    logic                enc_any;
    logic                xfer;

    // Request merge and service clear; a same-cycle load wins over the clear.
    always_comb begin
        load_vec          = load ? req_in : '0;
        clr_mask          = '0;
        clr_mask[code_q]  = 1'b1;
        next_pending      = (pending_q & ~clr_mask) | load_vec;
        xfer              = (state_q == PRESENT) && ready;
        // In IDLE only already-registered requests are eligible for selection.
        enc_vec           = (state_q == PRESENT) ? next_pending : pending_q;
    end

    pri_enc16 u_pri_enc16 (
        .vec (enc_vec),
        .idx (enc_idx),
        .any (enc_any)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else if (en) begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (enc_any) state_d = PRESENT;
            PRESENT: if (ready && !enc_any) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath next values: pending merge, code selection and valid.
    always_comb begin
        pending_d = pending_q | load_vec;
        code_d    = code_q;
        valid_d   = valid_q;
        unique case (state_q)
            IDLE: begin
                if (enc_any) begin
                    code_d  = enc_idx;
                    valid_d = 1'b1;
                end
            end
            PRESENT: begin
                if (xfer) begin
                    pending_d = next_pending;
                    if (enc_any) begin
                        code_d = enc_idx;
                    end else begin
                        valid_d = 1'b0;
                    end
                end
            end
            default: begin
                valid_d = 1'b0;
            end
        endcase
    end

    // Datapath registers; en=0 freezes everything.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q <= '0;
            code_q    <= '0;
            valid_q   <= 1'b0;
        end else if (en) begin
            pending_q <= pending_d;
            code_q    <= code_d;
            valid_q   <= valid_d;
        end
    end

    // Outputs straight from registers.
    always_comb begin
        code_out = code_q;
        valid    = valid_q;
        busy     = (|pending_q) | valid_q;
    end

endmodule

// File: tb/tb_encoder16x4_seq.sv
// Directed self-checking bench for encoder16x4_seq.
module tb_encoder16x4_seq;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic        load;
    logic [15:0] req_in;
    logic        ready;
    logic [3:0]  code_out;
    logic        valid;
    logic        busy;

    int errors = 0;
    int checks = 0;

    encoder16x4_seq dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .load     (load),
        .req_in   (req_in),
        .ready    (ready),
        .code_out (code_out),
        .valid    (valid),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle before sampling.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_out(input string tag, input logic v, input logic [3:0] c,
                             input logic b);
        check({tag, ".valid"}, {15'd0, valid}, {15'd0, v});
        if (v) check({tag, ".code"}, {12'd0, code_out}, {12'd0, c});
        check({tag, ".busy"}, {15'd0, busy}, {15'd0, b});
    endtask

    initial begin
        rst_n  = 1'b0;
        en     = 1'b1;
        load   = 1'b0;
        req_in = '0;
        ready  = 1'b0;
        repeat (2) step();
        check("rst.valid", {15'd0, valid}, 16'd0);
        check("rst.code", {12'd0, code_out}, 16'd0);
        check("rst.busy", {15'd0, busy}, 16'd0);
        rst_n = 1'b1;
        step();

        // Single request, code 5 valid for exactly one cycle.
        load = 1'b1; req_in = 16'h0020; ready = 1'b1;
        step(); load = 1'b0; req_in = '0;
        check_out("single.lat1", 1'b0, 4'd0, 1'b1);
        step(); check_out("single.pres", 1'b1, 4'd5, 1'b1);
        step(); check_out("single.done", 1'b0, 4'd0, 1'b0);
        step(); check_out("single.idle", 1'b0, 4'd0, 1'b0);

        // Multi-hot back-to-back: 15, 10, 5, 0.
        load = 1'b1; req_in = 16'h8421; ready = 1'b1;
        step(); load = 1'b0; req_in = '0;
        step(); check_out("multi.c15", 1'b1, 4'd15, 1'b1);
        step(); check_out("multi.c10", 1'b1, 4'd10, 1'b1);
        step(); check_out("multi.c5", 1'b1, 4'd5, 1'b1);
        step(); check_out("multi.c0", 1'b1, 4'd0, 1'b1);
        step(); check_out("multi.done", 1'b0, 4'd0, 1'b0);

        // Backpressure: 15 held for three cycles, then 15, 0.
        ready = 1'b0; load = 1'b1; req_in = 16'h8001;
        step(); load = 1'b0; req_in = '0;
        step(); check_out("bp.hold1", 1'b1, 4'd15, 1'b1);
        step(); check_out("bp.hold2", 1'b1, 4'd15, 1'b1);
        step(); check_out("bp.hold3", 1'b1, 4'd15, 1'b1);
        ready = 1'b1;
        step(); check_out("bp.c0", 1'b1, 4'd0, 1'b1);
        step(); check_out("bp.done", 1'b0, 4'd0, 1'b0);

        // Set beats clear, then a late higher arrival does not preempt.
        ready = 1'b0; load = 1'b1; req_in = 16'h0008;
        step(); load = 1'b0; req_in = '0;
        step(); check_out("sbc.c3", 1'b1, 4'd3, 1'b1);
        ready = 1'b1; load = 1'b1; req_in = 16'h0008;
        step(); check_out("sbc.again3", 1'b1, 4'd3, 1'b1);
        ready = 1'b0; load = 1'b1; req_in = 16'h4000;
        step(); load = 1'b0; req_in = '0;
        check_out("late.keep3a", 1'b1, 4'd3, 1'b1);
        step(); check_out("late.keep3b", 1'b1, 4'd3, 1'b1);
        ready = 1'b1;
        step(); check_out("late.c14", 1'b1, 4'd14, 1'b1);
        step(); check_out("late.done", 1'b0, 4'd0, 1'b0);
        ready = 1'b0;

        // Enable freeze with code 7 presented.
        load = 1'b1; req_in = 16'h0080;
        step(); load = 1'b0; req_in = '0;
        step(); check_out("frz.c7", 1'b1, 4'd7, 1'b1);
        en = 1'b0; ready = 1'b1; load = 1'b1; req_in = 16'hFFFF;
        for (int i = 0; i < 4; i++) begin
            step();
            check_out("frz.hold", 1'b1, 4'd7, 1'b1);
            check("frz.pending", dut.pending_q, 16'h0080);
        end
        en = 1'b1; load = 1'b0; req_in = '0; ready = 1'b1;
        step(); check_out("frz.done", 1'b0, 4'd0, 1'b0);
        ready = 1'b0;

        // Asynchronous reset in the middle of presenting.
        load = 1'b1; req_in = 16'h00F0;
        step(); load = 1'b0; req_in = '0;
        step(); check_out("mrst.c7", 1'b1, 4'd7, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check("mrst.valid", {15'd0, valid}, 16'd0);
        check("mrst.code", {12'd0, code_out}, 16'd0);
        check("mrst.busy", {15'd0, busy}, 16'd0);
        #1 rst_n = 1'b1;
        ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            check_out("mrst.after", 1'b0, 4'd0, 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/encoder16x4_seq.md
# encoder16x4_seq

Sequential 16-to-4 priority encoder, the inverse of the lab's 4-to-16 decoder. It accumulates one-hot or multi-hot request lines into a pending register. It then emits the binary index of each pending line, highest index first, one per valid/ready transfer, and clears each line as it is served. It sits between request sources (switches, decoder outputs, interrupt-style flags) and a consumer that takes one 4-bit code at a time.

## Interface
- N, 16, number of request lines; must be a power of two.
- CODE_W, 4, code width, equal to log2(N); derived, not overridden.

- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- en  input  1  global enable; 0 freezes all state and ignores every other input.
- load  input  1  when 1 (and en=1), req_in is ORed into the pending register.
- req_in  input  N  request lines; bit i requests code i.
- ready  input  1  consumer accepts code_out this cycle.
- code_out  output  CODE_W  binary index of the line being presented; registered.
- valid  output  1  code_out holds a pending request; registered.
- busy  output  1  (pending != 0) | valid; combinational from registers.

## Operation
- Registers:
  - pending[N-1:0]: set by load, cleared by service.
  - code_out and valid.
  - FSM state.
- Priority: the highest set index wins. A bit that is set is never served ahead of a higher set bit that was pending at selection time.
- FSM states:
  - IDLE: valid=0. If pending != 0, select the highest set bit, register code_out, set valid=1, and go to PRESENT. Otherwise stay.
  - PRESENT: valid=1. If ready=0, hold code_out, valid and state. If ready=1 (transfer):
    - next_pending = (pending with bit code_out cleared) | (load ? req_in : 0).
    - If next_pending != 0, present its highest bit on the next edge and stay in PRESENT (back-to-back).
    - Otherwise go to IDLE with valid=0 and code_out unchanged.
- Set beats clear: a load of bit k in the same cycle that bit k is accepted leaves bit k pending, so it is served again.
- Load while not accepting: pending |= req_in. This does not disturb the code currently presented, even if a higher bit arrives.
- load with req_in=0: no effect.
- en=0: pending, code_out, valid and state all hold. ready and load are ignored, so no transfer occurs even if valid=1 and ready=1.
- No overflow condition. Repeated requests for an already-pending bit merge into one service.

## Timing
- Reset (asynchronous, rst_n=0): pending=0, code_out=0, valid=0, state=IDLE, busy=0. This is immediate, including mid-transfer. Any request being presented is dropped.
- Load-to-valid latency: load sampled at edge k puts pending in place after k; valid=1 and code_out are set after edge k+1 (2 edges).
- Throughput: one code per clock while ready=1 and bits remain. Requests of m bits finish in m consecutive transfer cycles.
- code_out and valid are stable while valid=1 and ready=0.
- After the final transfer at edge j, valid=0 after j. busy falls after j unless a load occurred in the same cycle.
- busy rises the edge after a nonzero load.

## Structure
- Shared package encoder_pkg:
  - N and CODE_W constants.
  - FSM state encoding: IDLE=1'b0, PRESENT=1'b1.
- Sub-module pri_enc16: combinational, input vec[N-1:0], outputs idx[CODE_W-1:0] (highest set bit) and any (vec != 0). It is instantiated once, fed by next_pending in PRESENT and by pending in IDLE.
- The top holds the registers, the FSM and the set/clear merge logic.

## Test plan
- Single request: load=1, req_in=16'h0020 for one cycle, ready=1. Then valid=1 and code_out=5 two edges later, for exactly one cycle. Afterwards valid=0 and busy=0.
- Multi-hot, back-to-back: load 16'h8421, ready=1. code_out=15, 10, 5, 0 on four consecutive cycles, then valid=0.
- Backpressure: load 16'h8001 with ready=0 for 3 cycles. code_out=15 is held stable. Raise ready: 15 transfers, then 0 next cycle.
- Set beats clear and late arrival:
  - While 3 is being accepted, load 16'h0008. Code 3 is presented again on the next cycle.
  - While 3 is presented with ready=0, load 16'h4000. 3 stays presented, and 14 follows after acceptance.
- Enable freeze: with valid=1 and code_out=7, drive en=0, ready=1 and load=1, req_in=16'hFFFF for 4 cycles. All outputs are unchanged and pending is unchanged.
- Reset mid-operation: pending 16'h00F0 with valid=1. Pulse rst_n low between edges. Outputs go to 0 immediately and no codes are produced after release.
